// File: rtl/knapsack_search.sv
// Exhaustive 0-1 knapsack search: walks every selection vector in ascending order and keeps the best feasible one.
// Optional macro KNAPSACK_EARLY_EXIT_EN stops the walk at the first feasible candidate.
module knapsack_search #(
  parameter int N_ITEMS    = 5,
  parameter int W_WIDTH    = 5,
  parameter int V_WIDTH    = 5,
  parameter int MAX_WEIGHT = 15,
  parameter int MIN_VALUE  = 15,
  localparam int SW = W_WIDTH + $clog2(N_ITEMS) + 1,
  localparam int SV = V_WIDTH + $clog2(N_ITEMS) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N_ITEMS*W_WIDTH-1:0]   item_weight,
  input  logic [N_ITEMS*V_WIDTH-1:0]   item_value,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [N_ITEMS-1:0]           best_choices,
  output logic [SW-1:0]                best_weight,
  output logic [SV-1:0]                best_value
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SW-1:0] MAX_W = SW'(MAX_WEIGHT);
  localparam logic [SV-1:0] MIN_V = SV'(MIN_VALUE);

  state_t                       state_q, state_d;
  logic [N_ITEMS-1:0]           cand_q, cand_d;
  logic [N_ITEMS*W_WIDTH-1:0]   wt_q, wt_d;
  logic [N_ITEMS*V_WIDTH-1:0]   val_q, val_d;
  logic                         found_q, found_d;
  logic [N_ITEMS-1:0]           choices_q, choices_d;
  logic [SW-1:0]                bw_q, bw_d;
  logic [SV-1:0]                bv_q, bv_d;
  logic                         done_q, done_d;

  // Per-item contributions of the current candidate, zero when the item is not selected.
  logic [SW-1:0] term_w [N_ITEMS];
  logic [SV-1:0] term_v [N_ITEMS];

  genvar gi;
  generate
    for (gi = 0; gi < N_ITEMS; gi++) begin : g_term
      assign term_w[gi] = cand_q[gi] ? SW'(wt_q[gi*W_WIDTH +: W_WIDTH])  : '0;
      assign term_v[gi] = cand_q[gi] ? SV'(val_q[gi*V_WIDTH +: V_WIDTH]) : '0;
    end
  endgenerate

  logic [SW-1:0] sum_w;
  logic [SV-1:0] sum_v;
  logic          feasible;
  logic          better;
  logic          stop;

  always_comb begin
    sum_w = '0;
    sum_v = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      sum_w = sum_w + term_w[i];
      sum_v = sum_v + term_v[i];
    end
  end

  // Strict '>' keeps the lowest-index candidate among equal-value ties.
  assign feasible = (sum_w < MAX_W) && (sum_v >= MIN_V);
  assign better   = feasible && (!found_q || (sum_v > bv_q));

`ifdef KNAPSACK_EARLY_EXIT_EN
  assign stop = (&cand_q) || feasible;
`else
  assign stop = &cand_q;
`endif

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    wt_d      = wt_q;
    val_d     = val_q;
    found_d   = found_q;
    choices_d = choices_q;
    bw_d      = bw_q;
    bv_d      = bv_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          wt_d      = item_weight;
          val_d     = item_value;
          cand_d    = '0;
          found_d   = 1'b0;
          choices_d = '0;
          bw_d      = '0;
          bv_d      = '0;
        end
      end
      SCAN: begin
        cand_d = cand_q + 1'b1;
        if (better) begin
          found_d   = 1'b1;
          choices_d = cand_q;
          bw_d      = sum_w;
          bv_d      = sum_v;
        end
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      wt_q      <= '0;
      val_q     <= '0;
      found_q   <= 1'b0;
      choices_q <= '0;
      bw_q      <= '0;
      bv_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      wt_q      <= wt_d;
      val_q     <= val_d;
      found_q   <= found_d;
      choices_q <= choices_d;
      bw_q      <= bw_d;
      bv_q      <= bv_d;
      done_q    <= done_d;
    end
  end

  assign busy         = (state_q == SCAN);
  assign done         = done_q;
  assign found        = found_q;
  assign best_choices = choices_q;
  assign best_weight  = bw_q;
  assign best_value   = bv_q;

endmodule

// File: tb/tb_knapsack_search.sv
// Scoreboard bench for knapsack_search: three instances (defaults, raised MIN_VALUE, two items) checked against a brute-force model.
module tb_knapsack_search;

  typedef struct {
    bit found;
    int choices;
    int weight;
    int value;
    int lat;
    int e0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1, start2;
  logic [24:0] iw, iv;
  logic [9:0]  iw2, iv2;

  logic       busy0, done0, found0;
  logic [4:0] ch0;
  logic [8:0] bw0, bv0;
  logic       busy1, done1, found1;
  logic [4:0] ch1;
  logic [8:0] bw1, bv1;
  logic       busy2, done2, found2;
  logic [1:0] ch2;
  logic [6:0] bw2, bv2;

  knapsack_search dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .item_weight(iw), .item_value(iv),
    .busy(busy0), .done(done0), .found(found0), .best_choices(ch0),
    .best_weight(bw0), .best_value(bv0));

  knapsack_search #(.MIN_VALUE(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .item_weight(iw), .item_value(iv),
    .busy(busy1), .done(done1), .found(found1), .best_choices(ch1),
    .best_weight(bw1), .best_value(bv1));

  knapsack_search #(.N_ITEMS(2), .MAX_WEIGHT(2), .MIN_VALUE(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .item_weight(iw2), .item_value(iv2),
    .busy(busy2), .done(done2), .found(found2), .best_choices(ch2),
    .best_weight(bw2), .best_value(bv2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  exp_t q0[$], q1[$], q2[$];
  int w5[8], v5[8], w2[8], v2[8];
  int last_e0;

  // Brute force over every selection mask using plain integer sums.
  function automatic exp_t model(int n, int w[8], int v[8], int maxw, int minv);
    exp_t r;
    r = '{default: 0};
    r.lat = 1 << n;
    for (int m = 0; m < (1 << n); m++) begin
      int sw;
      int sv;
      sw = 0;
      sv = 0;
      for (int i = 0; i < n; i++) begin
        if (((m >> i) & 1) == 1) begin
          sw += w[i];
          sv += v[i];
        end
      end
      if (sw < maxw && sv >= minv) begin
`ifdef KNAPSACK_EARLY_EXIT_EN
        r.found = 1; r.choices = m; r.weight = sw; r.value = sv; r.lat = m + 1;
        return r;
`else
        if (!r.found || sv > r.value) begin
          r.found = 1; r.choices = m; r.weight = sw; r.value = sv;
        end
`endif
      end
    end
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cmp(string tag, exp_t e, logic f, int c, int w, int v);
    chk({tag, "_found"},   int'(f), int'(e.found));
    chk({tag, "_choices"}, c, e.choices);
    chk({tag, "_weight"},  w, e.weight);
    chk({tag, "_value"},   v, e.value);
    chk({tag, "_latency"}, cyc - e.e0, e.lat);
    $display("%s done: choices=%0d weight=%0d value=%0d found=%0d latency=%0d",
             tag, c, w, v, f, cyc - e.e0);
  endtask

  // Monitor: pops one expectation per done pulse on each instance.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (done0 === 1'b1) begin
          if (q0.size() == 0) chk("d0_unexpected_done", 1, 0);
          else cmp("d0", q0.pop_front(), found0, int'(ch0), int'(bw0), int'(bv0));
        end
        if (done1 === 1'b1) begin
          if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
          else cmp("d1", q1.pop_front(), found1, int'(ch1), int'(bw1), int'(bv1));
        end
        if (done2 === 1'b1) begin
          if (q2.size() == 0) chk("d2_unexpected_done", 1, 0);
          else cmp("d2", q2.pop_front(), found2, int'(ch2), int'(bw2), int'(bv2));
        end
      end
    end
  end

  task automatic pack_items();
    for (int i = 0; i < 5; i++) begin
      iw[i*5 +: 5] = w5[i][4:0];
      iv[i*5 +: 5] = v5[i][4:0];
    end
    for (int i = 0; i < 2; i++) begin
      iw2[i*5 +: 5] = w2[i][4:0];
      iv2[i*5 +: 5] = v2[i][4:0];
    end
  endtask

  task automatic set_plan_items();
    w5 = '{12, 1, 2, 1, 4, 0, 0, 0};
    v5 = '{4, 2, 2, 1, 10, 0, 0, 0};
    w2 = '{1, 1, 0, 0, 0, 0, 0, 0};
    v2 = '{5, 5, 0, 0, 0, 0, 0, 0};
    pack_items();
  endtask

  task automatic set_random_items();
    for (int i = 0; i < 5; i++) begin
      w5[i] = $urandom_range(0, 10);
      v5[i] = $urandom_range(0, 14);
    end
    for (int i = 0; i < 2; i++) begin
      w2[i] = $urandom_range(0, 3);
      v2[i] = $urandom_range(0, 8);
    end
    pack_items();
  endtask

  task automatic issue(bit d0, bit d1, bit d2);
    exp_t e;
    @(negedge clk);
    last_e0 = cyc + 1;
    if (d0) begin e = model(5, w5, v5, 15, 15); e.e0 = last_e0; q0.push_back(e); start0 = 1'b1; end
    if (d1) begin e = model(5, w5, v5, 15, 16); e.e0 = last_e0; q1.push_back(e); start1 = 1'b1; end
    if (d2) begin e = model(2, w2, v2, 2, 5);   e.e0 = last_e0; q2.push_back(e); start2 = 1'b1; end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_all();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      chk("done_timeout", q0.size() + q1.size() + q2.size(), 0);
      q0.delete(); q1.delete(); q2.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e, e2;
    rst_n  = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    iw = '0; iv = '0; iw2 = '0; iv2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",    int'(busy0), 0);
    chk("reset_done",    int'(done0), 0);
    chk("reset_found",   int'(found0), 0);
    chk("reset_choices", int'(ch0), 0);
    chk("reset_weight",  int'(bw0), 0);
    chk("reset_value",   int'(bv0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plan items on all three instances.
    set_plan_items();
    issue(1, 1, 1);
    repeat (3) @(negedge clk);
    chk("busy_during_scan", int'(busy0), 1);
    wait_all();
    chk("plan_choices", int'(ch0), 5'b11110);
    chk("plan_weight",  int'(bw0), 8);
    chk("plan_value",   int'(bv0), 15);
    chk("plan_nofeas_found", int'(found1), 0);
    chk("tie_choices",  int'(ch2), 2'b01);

    // Extra start pulses and weight changes while scanning must be ignored.
    issue(1, 1, 0);
    while (cyc < last_e0 + 5) @(negedge clk);
    start0 = 1'b1; start1 = 1'b1; iw = 25'h1ABCDE5;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    while (cyc < last_e0 + 10) @(negedge clk);
    start0 = 1'b1; start1 = 1'b1; iw = 25'h0F0F0F0;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    wait_all();

    // Reset mid-scan discards everything, then a fresh search completes.
    set_plan_items();
    issue(1, 1, 0);
    while (cyc < last_e0 + 12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",    int'(busy0), 0);
    chk("midrst_found",   int'(found0), 0);
    chk("midrst_choices", int'(ch0), 0);
    chk("midrst_weight",  int'(bw0), 0);
    chk("midrst_value",   int'(bv0), 0);
    chk("midrst_busy1",   int'(busy1), 0);
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(1, 1, 0);
    wait_all();

    // Start held high: second search begins in the done cycle.
    set_random_items();
    @(negedge clk);
    e = model(5, w5, v5, 15, 15);
    e.e0 = cyc + 1;
    e2 = e;
    e2.e0 = e.e0 + e.lat + 1;
    q0.push_back(e);
    q0.push_back(e2);
    start0 = 1'b1;
    while (cyc < e2.e0) @(negedge clk);
    start0 = 1'b0;
    wait_all();

    for (int t = 0; t < 8; t++) begin
      set_random_items();
      issue(1, 1, 1);
      wait_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
